// File: rtl/rifl_pkg.sv
// rtl/rifl_pkg.sv - shared CRC defaults and serial-equivalent parallel CRC step for RIFL TX/RX
package rifl_pkg;

    localparam int CRC_MAX_W  = 32;
    localparam int DATA_MAX_W = 256;

    localparam logic [11:0] CRC_POLY_DEFAULT = 12'h80F;
    localparam logic [11:0] CRC_INIT_DEFAULT = 12'h000;

    // MSB-first LFSR over the low dw bits of data; with constant dw/cw the loop collapses to an XOR tree.
    function automatic logic [CRC_MAX_W-1:0] crc_step(
        input logic [CRC_MAX_W-1:0]  crc,
        input logic [DATA_MAX_W-1:0] data,
        input int                    dw,
        input int                    cw,
        input logic [CRC_MAX_W-1:0]  poly
    );
        logic [CRC_MAX_W-1:0] c;
        logic [CRC_MAX_W-1:0] mask;
        logic                 fb;
        mask = (CRC_MAX_W'(1) << cw) - CRC_MAX_W'(1);
        c    = crc & mask;
        for (int i = DATA_MAX_W - 1; i >= 0; i--) begin
            if (i < dw) begin
                fb = c[cw-1] ^ data[i];
                c  = ((c << 1) ^ (fb ? poly : '0)) & mask;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/rifl_crc_insert_if.sv
// rtl/rifl_crc_insert_if.sv - beat stream in/out bundle for the RIFL CRC insert/check stage
interface rifl_crc_insert_if #(
    parameter int DWIDTH = 64
);
    logic              sof;
    logic [DWIDTH-1:0] data_in;
    logic              sof_out;
    logic [DWIDTH-1:0] data_out;
    logic              eof_out;
    logic              crc_err;
    logic              frame_err;

    modport master (
        output sof, data_in,
        input  sof_out, data_out, eof_out, crc_err, frame_err
    );

    modport slave (
        input  sof, data_in,
        output sof_out, data_out, eof_out, crc_err, frame_err
    );
endinterface

// File: rtl/rifl_crc_step.sv
// rtl/rifl_crc_step.sv - combinational parallel CRC over a W-bit slice, MSB first
module rifl_crc_step
    import rifl_pkg::*;
#(
    parameter int                   W         = 64,
    parameter int                   CRC_WIDTH = 12,
    parameter logic [CRC_WIDTH-1:0] CRC_POLY  = CRC_POLY_DEFAULT
) (
    input  logic [CRC_WIDTH-1:0] crc_in,
    input  logic [W-1:0]         data,
    output logic [CRC_WIDTH-1:0] crc_out
);

    assign crc_out = CRC_WIDTH'(crc_step(CRC_MAX_W'(crc_in), DATA_MAX_W'(data), W, CRC_WIDTH,
                                         CRC_MAX_W'(CRC_POLY)));

endmodule

// File: rtl/rifl_crc_insert.sv
// rtl/rifl_crc_insert.sv - RIFL frame CRC insert (TX) / check (RX) stage, one clk latency
module rifl_crc_insert
    import rifl_pkg::*;
#(
    parameter int                   FRAME_WIDTH = 256,
    parameter int                   DWIDTH      = 64,
    parameter int                   CRC_WIDTH   = 12,
    parameter logic [CRC_WIDTH-1:0] CRC_POLY    = CRC_POLY_DEFAULT,
    parameter logic [CRC_WIDTH-1:0] CRC_INIT    = CRC_INIT_DEFAULT,
    parameter bit                   CHECK       = 1'b0
) (
    input logic               clk,
    input logic               rst_n,
    rifl_crc_insert_if.slave  bus
);

    localparam int PIP_CYCLES = FRAME_WIDTH / DWIDTH;
    localparam int CNT_W      = (PIP_CYCLES > 1) ? $clog2(PIP_CYCLES) : 1;

    logic [CNT_W-1:0]     cnt;
    logic                 active;
    logic [CRC_WIDTH-1:0] acc;
    logic [CRC_WIDTH-1:0] seed;
    logic [CRC_WIDTH-1:0] crc_body;
    logic [CRC_WIDTH-1:0] crc_final;
    logic                 last;
    logic                 fire;
    logic [DWIDTH-1:0]    data_nxt;
    logic                 err_nxt;

    // A sof beat is index 0 regardless of the counter, so it always restarts from the seed.
    assign seed = bus.sof ? CRC_INIT : acc;
    assign last = bus.sof ? (PIP_CYCLES == 1) : (cnt == CNT_W'(PIP_CYCLES - 1));
    assign fire = last && (active || bus.sof);

    generate
        if (PIP_CYCLES > 1) begin : g_body
            rifl_crc_step #(
                .W(DWIDTH), .CRC_WIDTH(CRC_WIDTH), .CRC_POLY(CRC_POLY)
            ) u_body (
                .crc_in(seed), .data(bus.data_in), .crc_out(crc_body)
            );
        end else begin : g_no_body
            assign crc_body = '0;
        end
    endgenerate

    rifl_crc_step #(
        .W(DWIDTH - CRC_WIDTH), .CRC_WIDTH(CRC_WIDTH), .CRC_POLY(CRC_POLY)
    ) u_last (
        .crc_in(seed), .data(bus.data_in[DWIDTH-1:CRC_WIDTH]), .crc_out(crc_final)
    );

    generate
        if (CHECK) begin : g_check
            assign data_nxt = bus.data_in;
            assign err_nxt  = fire && (crc_final != bus.data_in[CRC_WIDTH-1:0]);
        end else begin : g_insert
            assign data_nxt = fire ? {bus.data_in[DWIDTH-1:CRC_WIDTH], crc_final} : bus.data_in;
            assign err_nxt  = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.sof_out   <= 1'b0;
            bus.data_out  <= '0;
            bus.eof_out   <= 1'b0;
            bus.crc_err   <= 1'b0;
            bus.frame_err <= 1'b0;
            cnt           <= '0;
            active        <= 1'b0;
            acc           <= '0;
        end else begin
            bus.sof_out   <= bus.sof;
            bus.data_out  <= data_nxt;
            bus.eof_out   <= fire;
            bus.crc_err   <= err_nxt;
            bus.frame_err <= bus.sof && active && (cnt != '0);
            if (bus.sof) begin
                acc    <= crc_body;
                cnt    <= (PIP_CYCLES == 1) ? '0 : CNT_W'(1);
                active <= (PIP_CYCLES != 1);
            end else if (active) begin
                acc <= crc_body;
                if (cnt == CNT_W'(PIP_CYCLES - 1)) begin
                    cnt    <= '0;
                    active <= 1'b0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_rifl_crc_insert.sv
// tb/tb_rifl_crc_insert.sv - randomized bench: insert stage looped into a check stage vs. long-division model
module tb_rifl_crc_insert;

    localparam int          FW        = 256;
    localparam int          DW        = 64;
    localparam int          CRCW      = 12;
    localparam int          P         = FW / DW;
    localparam logic [11:0] POLY      = 12'h80F;
    localparam logic [63:0] FLIP_MASK = 64'h1 << 40;

    typedef struct packed {
        logic          sof;
        logic [DW-1:0] data;
        logic          eof;
        logic          crc_err;
        logic          frame_err;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    logic flip;

    always #5 clk = ~clk;

    rifl_crc_insert_if #(.DWIDTH(DW)) ins_if ();
    rifl_crc_insert_if #(.DWIDTH(DW)) chk_if ();

    assign chk_if.sof     = ins_if.sof_out;
    assign chk_if.data_in = ins_if.data_out ^ (flip ? FLIP_MASK : 64'h0);

    rifl_crc_insert #(
        .FRAME_WIDTH(FW), .DWIDTH(DW), .CRC_WIDTH(CRCW),
        .CRC_POLY(POLY), .CRC_INIT(12'h000), .CHECK(1'b0)
    ) u_ins (
        .clk(clk), .rst_n(rst_n), .bus(ins_if)
    );

    rifl_crc_insert #(
        .FRAME_WIDTH(FW), .DWIDTH(DW), .CRC_WIDTH(CRCW),
        .CRC_POLY(POLY), .CRC_INIT(12'h000), .CHECK(1'b1)
    ) u_chk (
        .clk(clk), .rst_n(rst_n), .bus(chk_if)
    );

    int          checks;
    int          errors;
    int          pos_ins;
    int          pos_chk;
    logic [FW-1:0] fr_ins;
    logic [FW-1:0] fr_chk;
    beat_t       prev_ins;
    beat_t       obs_ins;
    beat_t       obs_chk;

    // Remainder of the frame (CRC field zeroed, i.e. message * x^12) divided by the full generator.
    function automatic logic [11:0] ref_crc(input logic [FW-1:0] frame);
        logic [FW-1:0] m;
        m       = frame;
        m[11:0] = 12'h000;
        for (int i = FW - 1; i >= CRCW; i--)
            if (m[i]) m[i -: 13] = m[i -: 13] ^ {1'b1, POLY};
        return m[11:0];
    endfunction

    task automatic model(input bit chk, input logic s, input logic [DW-1:0] d,
                         inout int pos, inout logic [FW-1:0] fr, output beat_t o);
        int idx;
        logic [11:0] c;
        o           = '0;
        o.sof       = s;
        o.data      = d;
        idx         = -1;
        if (s) begin
            o.frame_err = (pos != 0);
            idx         = 0;
        end else if (pos != 0) begin
            idx = pos;
        end
        if (idx >= 0) begin
            fr[(P-1-idx)*DW +: DW] = d;
            if (idx == P - 1) begin
                c     = ref_crc(fr);
                o.eof = 1'b1;
                if (chk) o.crc_err = (c != d[11:0]);
                else     o.data[11:0] = c;
                pos = 0;
            end else begin
                pos = idx + 1;
            end
        end
    endtask

    task automatic step(input string tn, input logic r, input logic s,
                        input logic [DW-1:0] d, input logic fl);
        beat_t e_ins;
        beat_t e_chk;
        rst_n          = r;
        ins_if.sof     = s;
        ins_if.data_in = d;
        flip           = fl;
        @(posedge clk);
        #1;
        if (!r) begin
            e_ins   = '0;
            e_chk   = '0;
            pos_ins = 0;
            pos_chk = 0;
        end else begin
            model(1'b1, prev_ins.sof, prev_ins.data ^ (fl ? FLIP_MASK : 64'h0), pos_chk, fr_chk, e_chk);
            model(1'b0, s, d, pos_ins, fr_ins, e_ins);
        end
        prev_ins = e_ins;
        obs_ins  = {ins_if.sof_out, ins_if.data_out, ins_if.eof_out, ins_if.crc_err, ins_if.frame_err};
        obs_chk  = {chk_if.sof_out, chk_if.data_out, chk_if.eof_out, chk_if.crc_err, chk_if.frame_err};
        checks++;
        if (obs_ins !== e_ins) begin
            errors++;
            $display("FAIL %s ins beat: got %h expected %h", tn, obs_ins, e_ins);
        end
        checks++;
        if (obs_chk !== e_chk) begin
            errors++;
            $display("FAIL %s chk beat: got %h expected %h", tn, obs_chk, e_chk);
        end
    endtask

    function automatic logic [DW-1:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step("reset", 1'b0, 1'($urandom_range(0, 1)), rnd64(), 1'b0);
        checks++;
        if (obs_ins !== beat_t'(0)) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", obs_ins);
        end
        step("first_sof", 1'b1, 1'b1, rnd64(), 1'b0);
        checks++;
        if (obs_ins.sof !== 1'b1) begin
            errors++;
            $display("FAIL first_sof_out: got %b expected 1", obs_ins.sof);
        end
        for (int i = 1; i < P; i++) step("first_frame", 1'b1, 1'b0, rnd64(), 1'b0);
    endtask

    task automatic test_zero_frame();
        for (int i = 0; i < P; i++) step("zero_frame", 1'b1, (i == 0), 64'h0, 1'b0);
        checks++;
        if (obs_ins.eof !== 1'b1 || obs_ins.data !== 64'h0) begin
            errors++;
            $display("FAIL zero_frame_last: got eof=%b data=%h expected eof=1 data=0", obs_ins.eof, obs_ins.data);
        end
    endtask

    task automatic test_single_bit();
        for (int i = 0; i < P; i++)
            step("single_bit", 1'b1, (i == 0), (i == P - 1) ? 64'h1000 : 64'h0, 1'b0);
        checks++;
        if (obs_ins.data !== 64'h180F || obs_ins.eof !== 1'b1) begin
            errors++;
            $display("FAIL single_bit_crc: got data=%h eof=%b expected 180f eof=1", obs_ins.data, obs_ins.eof);
        end
    endtask

    task automatic test_loopback();
        for (int i = 0; i < P; i++) step("loop_good", 1'b1, (i == 0), rnd64(), 1'b0);
        step("loop_good_flush", 1'b1, 1'b0, rnd64(), 1'b0);
        checks++;
        if (obs_chk.eof !== 1'b1 || obs_chk.crc_err !== 1'b0) begin
            errors++;
            $display("FAIL loop_good: got eof=%b crc_err=%b expected eof=1 crc_err=0", obs_chk.eof, obs_chk.crc_err);
        end
        // The checker consumes insert-output beat 1 while beat 2 is being driven.
        for (int i = 0; i < P; i++) step("loop_flip", 1'b1, (i == 0), rnd64(), (i == 2));
        step("loop_flip_flush", 1'b1, 1'b0, rnd64(), 1'b0);
        checks++;
        if (obs_chk.eof !== 1'b1 || obs_chk.crc_err !== 1'b1) begin
            errors++;
            $display("FAIL loop_flip: got eof=%b crc_err=%b expected eof=1 crc_err=1", obs_chk.eof, obs_chk.crc_err);
        end
    endtask

    task automatic test_abort();
        step("abort_old", 1'b1, 1'b1, rnd64(), 1'b0);
        step("abort_old", 1'b1, 1'b0, rnd64(), 1'b0);
        step("abort_new", 1'b1, 1'b1, 64'h0, 1'b0);
        checks++;
        if (obs_ins.frame_err !== 1'b1 || obs_ins.sof !== 1'b1 || obs_ins.eof !== 1'b0) begin
            errors++;
            $display("FAIL abort_pulse: got ferr=%b sof=%b eof=%b expected 1 1 0",
                     obs_ins.frame_err, obs_ins.sof, obs_ins.eof);
        end
        for (int i = 1; i < P; i++)
            step("abort_frame", 1'b1, 1'b0, (i == P - 1) ? 64'h1000 : 64'h0, 1'b0);
        checks++;
        if (obs_ins.data[11:0] !== 12'h80F) begin
            errors++;
            $display("FAIL abort_new_crc: got %h expected 80f", obs_ins.data[11:0]);
        end
        step("abort_flush", 1'b1, 1'b0, rnd64(), 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 8; f++)
            for (int i = 0; i < P; i++) step("b2b", 1'b1, (i == 0), rnd64(), 1'b0);
        for (int i = 0; i < 5; i++) step("idle", 1'b1, 1'b0, rnd64(), 1'b0);
        step("mid_reset_frame", 1'b1, 1'b1, rnd64(), 1'b0);
        step("mid_reset_frame", 1'b1, 1'b0, rnd64(), 1'b0);
        step("mid_reset", 1'b0, 1'b0, rnd64(), 1'b0);
        step("mid_reset", 1'b0, 1'b0, rnd64(), 1'b0);
        for (int i = 0; i < P; i++) begin
            step("after_reset", 1'b1, 1'b0, rnd64(), 1'b0);
            checks++;
            if (obs_ins.eof !== 1'b0) begin
                errors++;
                $display("FAIL after_reset_eof: got %b expected 0", obs_ins.eof);
            end
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        flip           = 1'b0;
        prev_ins       = '0;
        pos_ins        = 0;
        pos_chk        = 0;
        fr_ins         = '0;
        fr_chk         = '0;
        rst_n          = 1'b0;
        ins_if.sof     = 1'b0;
        ins_if.data_in = '0;
        test_reset();
        test_zero_frame();
        test_single_bit();
        test_loopback();
        test_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
